// File: rtl/channel_pkg.sv
// Shared types and default widths for the channel read/write path.
package channel_pkg;

    localparam int CH_ADDR_W = 64;
    localparam int CH_CNT_W  = 32;

    // One job: read `count` blocks starting at `addr`, `stride` bytes apart.
    typedef struct packed {
        logic [CH_ADDR_W-1:0] addr;
        logic [CH_CNT_W-1:0]  count;
        logic [CH_CNT_W-1:0]  stride;
    } job_desc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } gen_state_t;

endpackage

// File: rtl/channel_cmd_gen_if.sv
// Job, command and status signals of the channel command generator.
interface channel_cmd_gen_if
    import channel_pkg::*;
#(
    parameter int ADDR_W = CH_ADDR_W,
    parameter int CNT_W  = CH_CNT_W
);
    logic              io_job_valid;
    logic              io_job_ready;
    logic [ADDR_W-1:0] io_job_bits_addr;
    logic [CNT_W-1:0]  io_job_bits_count;
    logic [CNT_W-1:0]  io_job_bits_stride;
    logic              io_cmd_out_valid;
    logic              io_cmd_out_ready;
    logic [ADDR_W-1:0] io_cmd_out_bits_addr;
    logic              io_blk_done;
    logic              io_busy;
    logic [CNT_W-1:0]  io_issued_cnt;
    logic              io_err_overrun;

    // The side that submits jobs, consumes commands and reports completions.
    modport master (
        output io_job_valid, io_job_bits_addr, io_job_bits_count, io_job_bits_stride,
        input  io_job_ready,
        input  io_cmd_out_valid, io_cmd_out_bits_addr,
        output io_cmd_out_ready,
        output io_blk_done,
        input  io_busy, io_issued_cnt, io_err_overrun
    );

    // The generator itself.
    modport slave (
        input  io_job_valid, io_job_bits_addr, io_job_bits_count, io_job_bits_stride,
        output io_job_ready,
        output io_cmd_out_valid, io_cmd_out_bits_addr,
        input  io_cmd_out_ready,
        input  io_blk_done,
        output io_busy, io_issued_cnt, io_err_overrun
    );
endinterface

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with a sticky overrun flag.
// Starts full; a completion arriving while already full is flagged, not counted.
module credit_counter #(
    parameter  int MAX = 8,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_d_o,
    output logic         overrun_o
);
    localparam logic [W-1:0] FULL = W'(MAX);

    logic [W-1:0] count_q, count_d;
    logic         overrun_q, overrun_d;

    // Next credit value: simultaneous return and spend cancel out.
    always_comb begin
        count_d   = count_q;
        overrun_d = overrun_q;
        if (en_i) begin
            if (inc_i && !dec_i) begin
                if (count_q == FULL) begin
                    overrun_d = 1'b1;
                end else begin
                    count_d = count_q + W'(1);
                end
            end else if (dec_i && !inc_i && count_q != '0) begin
                count_d = count_q - W'(1);
            end
        end
    end

    // Credit and overrun registers; reset refills all credits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= FULL;
            overrun_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign count_o   = count_q;
    assign count_d_o = count_d;
    assign overrun_o = overrun_q;
endmodule

// File: rtl/channel_cmd_gen.sv
// Expands a job descriptor into per-block read addresses, throttled by
// completion credits so no more than MAX_OUTSTANDING blocks are in flight.
module channel_cmd_gen
    import channel_pkg::*;
#(
    parameter int ADDR_W          = CH_ADDR_W,
    parameter int CNT_W           = CH_CNT_W,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clock,
    input  logic              reset,
    channel_cmd_gen_if.slave  bus
);
    localparam int              CRED_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_OUTSTANDING);

    gen_state_t        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] stride_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [CNT_W-1:0]  issued_q;
    logic              valid_q;
    logic              job_ready_q;
    logic              busy_q;
    logic [CRED_W-1:0] credits_q;
    logic [CRED_W-1:0] credits_d;
    logic              overrun_q;
    logic              cmd_hs;
    logic              job_hs;
    logic              credit_en;

    assign cmd_hs    = valid_q && bus.io_cmd_out_ready;
    assign job_hs    = bus.io_job_valid && job_ready_q;
    assign credit_en = (state_q != IDLE);

    credit_counter #(.MAX(MAX_OUTSTANDING)) u_credit (
        .clock     (clock),
        .reset     (reset),
        .en_i      (credit_en),
        .inc_i     (bus.io_blk_done),
        .dec_i     (cmd_hs),
        .count_o   (credits_q),
        .count_d_o (credits_d),
        .overrun_o (overrun_q)
    );

    // Job FSM with registered outputs; valid is recomputed from next-cycle credits
    // so it can only fall after a handshake has consumed the last credit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            issued_q    <= '0;
            valid_q     <= 1'b0;
            job_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (job_hs) begin
                        issued_q <= '0;
                        if (bus.io_job_bits_count != '0) begin
                            addr_q      <= bus.io_job_bits_addr;
                            stride_q    <= ADDR_W'(bus.io_job_bits_stride);
                            remaining_q <= bus.io_job_bits_count;
                            valid_q     <= 1'b1;
                            job_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_hs) begin
                        addr_q      <= addr_q + stride_q;
                        remaining_q <= remaining_q - CNT_W'(1);
                        issued_q    <= issued_q + CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            valid_q <= 1'b0;
                            state_q <= DRAIN;
                        end else begin
                            valid_q <= (credits_d != '0);
                        end
                    end else begin
                        valid_q <= (credits_d != '0);
                    end
                end
                DRAIN: begin
                    if (credits_d == CRED_MAX) begin
                        job_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.io_job_ready         = job_ready_q;
    assign bus.io_cmd_out_valid     = valid_q;
    assign bus.io_cmd_out_bits_addr = addr_q;
    assign bus.io_busy              = busy_q;
    assign bus.io_issued_cnt        = issued_q;
    assign bus.io_err_overrun       = overrun_q;
endmodule

// File: doc/channel_cmd_gen.md
Name: channel_cmd_gen

Overview:
- Upstream command generator for the channel read path.
- Accepts one job descriptor (base address, block count, stride) and expands it into a stream of 64-bit per-block read addresses on a valid/ready port that feeds the channel reader's command input.
- Limits the number of outstanding blocks with a credit counter. A credit is returned each time the reader's output stream completes a block (a `last` beat is handshaken).

Parameters:
- ADDR_W, 64, width of job base address and emitted command address
- CNT_W, 32, width of block count and stride fields
- MAX_OUTSTANDING, 8, credits available, i.e. max blocks issued but not yet completed (>=1)

Ports:
- clock  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- io_job_valid  input  1  job descriptor valid
- io_job_ready  output  1  job descriptor accepted when valid&ready
- io_job_bits_addr  input  ADDR_W  base address of first block
- io_job_bits_count  input  CNT_W  number of blocks to issue
- io_job_bits_stride  input  CNT_W  byte increment between block addresses, zero-extended to ADDR_W
- io_cmd_out_valid  output  1  command address valid
- io_cmd_out_ready  input  1  downstream (reader cmd_in) ready
- io_cmd_out_bits_addr  output  ADDR_W  block read address
- io_blk_done  input  1  one-cycle pulse per completed block (reader out valid&ready&last)
- io_busy  output  1  job in progress
- io_issued_cnt  output  CNT_W  commands issued in the current/last job
- io_err_overrun  output  1  sticky: blk_done received with no block outstanding

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE, io_job_ready=1, io_cmd_out_valid=0, io_cmd_out_bits_addr=0
  - io_busy=0, io_issued_cnt=0, io_err_overrun=0, credits=MAX_OUTSTANDING, remaining=0
- Reset asserted mid-job aborts the job immediately. Outstanding blocks are forgotten, and later blk_done pulses are ignored while in IDLE.
- State IDLE:
  - io_job_ready=1.
  - On job handshake with count>0: latch addr/stride, set remaining=count, clear issued_cnt, go to ISSUE.
  - On job handshake with count=0: accepted, issued_cnt cleared, stay in IDLE, busy stays 0.
- State ISSUE:
  - io_job_ready=0, busy=1.
  - io_cmd_out_valid = (remaining>0 && credits>0), registered.
  - Latency: job accepted on edge N → io_cmd_out_valid=1 in the cycle after edge N, when credits allow.
  - On cmd handshake:
    - addr += stride, modulo 2^ADDR_W (wraps silently)
    - remaining--, credits--, issued_cnt++
  - Once valid is raised, valid and addr are held stable until the handshake. Credits only decrease on a handshake, so valid can never drop before it.
  - Back-to-back: one command per cycle while io_cmd_out_ready=1 and credits>0.
  - When the last command handshakes (remaining 1→0), go to DRAIN.
- State DRAIN:
  - busy=1, no commands.
  - When credits==MAX_OUTSTANDING, including the cycle in which the final blk_done arrives, go to IDLE. job_ready=1 on the next cycle.
- Credit accounting, in any non-IDLE state:
  - blk_done alone: credits++.
  - Handshake alone: credits--.
  - Both in the same cycle: credits unchanged.
  - blk_done while credits==MAX_OUTSTANDING (no handshake): credits unchanged, io_err_overrun←1 (sticky until reset).
- Width rules:
  - credits counter is clog2(MAX_OUTSTANDING+1) bits.
  - remaining and issued_cnt are CNT_W bits.
  - count=2^CNT_W-1 is legal.

Decomposition:
- Shared package `channel_pkg`:
  - job descriptor struct (addr, count, stride)
  - state enum (IDLE, ISSUE, DRAIN)
  - default ADDR_W/CNT_W constants, shared with the channel reader/writer
- One natural sub-module: `credit_counter`, a saturating up/down counter with overrun flag, reusable by a future write-side generator.
- The address/remaining datapath stays in the top module.

Test Plan:
- Reset and basic job:
  - Stimulus: reset low 100 cycles, release; job addr=0x1000, count=4, stride=0x400; cmd ready=1 always; blk_done pulsed 20 cycles after each handshake.
  - Expected: addrs 0x1000, 0x1400, 0x1800, 0x1C00 on 4 consecutive cycles; busy drops and job_ready=1 one cycle after the 4th blk_done; issued_cnt=4.
- Credit stall:
  - Stimulus: MAX_OUTSTANDING=8, count=12, no blk_done until the 8th handshake.
  - Expected: exactly 8 commands, then valid=0. Each blk_done allows exactly one more command; 12 total.
- Backpressure stability:
  - Stimulus: io_cmd_out_ready toggling randomly.
  - Expected: addr/valid never change while valid=1 and ready=0; sequence 0, stride, 2·stride, … unbroken.
- Boundary conditions:
  - count=0 job → no command, job_ready stays 1.
  - addr=0xFFFF_FFFF_FFFF_FC00, stride=0x400, count=2 → second addr=0x0.
  - Simultaneous handshake+blk_done at credits=1 → credits stays 1 and the next command issues the following cycle.
- Overrun: blk_done pulsed with no outstanding block → io_err_overrun=1 and credits stay 8.
- Mid-job reset: reset low mid-job for 3 cycles → outputs at reset values immediately (async); a new job then runs correctly.
